// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent debouncers. Each channel has a two-flop
// synchroniser, a stability-window filter, single-cycle rise/fall pulses
// and a one-shot long-press (hold) detector. All outputs are registered.
module debounce_bank #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned STABLE_CYCLES = 240000,
    parameter int unsigned HOLD_CYCLES   = 100000000,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] hold_pulse
);

    // Stability counter only ever reaches STABLE_CYCLES-1, so it never wraps.
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic          s1;
        logic          s2;
        logic          clean;
        logic          rise;
        logic          fall;
        logic          hold;
        logic [CW-1:0] cnt;

        // Two-flop synchroniser for the asynchronous pin level.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1 <= INIT_LEVEL;
                s2 <= INIT_LEVEL;
            end else begin
                s1 <= raw_in[i];
                s2 <= s1;
            end
        end

        // Stability window: s2 must differ from the clean level for
        // STABLE_CYCLES consecutive cycles; any return restarts the window.
        // Edge pulses are registered on the same edge that updates clean.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt   <= '0;
                clean <= INIT_LEVEL;
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                rise <= 1'b0;
                fall <= 1'b0;
                if (s2 == clean) begin
                    cnt <= '0;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    clean <= s2;
                    cnt   <= '0;
                    rise  <= s2;
                    fall  <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
            logic [HW-1:0] hcnt;

            // Long-press detector: hcnt saturates at HOLD_CYCLES so the
            // pulse fires once per press and needs a fall to re-arm.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hcnt <= '0;
                    hold <= 1'b0;
                end else begin
                    if (!clean) begin
                        hcnt <= '0;
                    end else if (hcnt < HW'(HOLD_CYCLES)) begin
                        hcnt <= hcnt + 1'b1;
                    end
                    hold <= clean && (hcnt == HW'(HOLD_CYCLES - 1));
                end
            end
        end else begin : g_nohold
            assign hold = 1'b0;
        end

        assign clean_out[i]  = clean;
        assign rise_pulse[i] = rise;
        assign fall_pulse[i] = fall;
        assign hold_pulse[i] = hold;
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Testbench for debounce_bank: directed stimulus pushes hand-computed pulse
// events (kind, channel, cycle) into a scoreboard; a monitor on the falling
// edge matches every observed pulse against it. Leftover events are misses.
`timescale 1ns/1ps
module tb_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] raw_in;
    logic [3:0] clean_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic [3:0] hold_pulse;

    debounce_bank #(
        .N_CH         (4),
        .STABLE_CYCLES(8),
        .HOLD_CYCLES  (20),
        .INIT_LEVEL   (1'b0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .hold_pulse(hold_pulse)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge n, cyc reads n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 rise, 1 fall, 2 hold
        int ch;
        int at;
    } ev_t;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    function automatic string kname(input int k);
        case (k)
            0:       return "rise";
            1:       return "fall";
            default: return "hold";
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int k, input int c, input int at);
        ev_t ev;
        ev.kind = k;
        ev.ch   = c;
        ev.at   = at;
        sb.push_back(ev);
    endtask

    task automatic check_clean(input logic [3:0] exp, input string name);
        n_checks++;
        if (clean_out !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): clean_out=%b required %b", name, cyc, clean_out, exp);
        end
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if ({clean_out, rise_pulse, fall_pulse, hold_pulse} !== 16'h0) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): clean=%b rise=%b fall=%b hold=%b required all 0",
                     name, cyc, clean_out, rise_pulse, fall_pulse, hold_pulse);
        end
    endtask

    // Monitor: every asserted pulse bit must match a pending scoreboard entry.
    logic [3:0] p [3];
    bit         found;
    always @(negedge clk) begin
        p[0] = rise_pulse;
        p[1] = fall_pulse;
        p[2] = hold_pulse;
        n_checks++;
        if ((rise_pulse & fall_pulse) != 4'h0) begin
            n_fail++;
            $display("FAIL rise_fall_excl (cycle %0d): rise=%b fall=%b required disjoint",
                     cyc, rise_pulse, fall_pulse);
        end
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (p[k][c] === 1'b1) begin
                    n_checks++;
                    found = 1'b0;
                    for (int j = 0; j < sb.size(); j++) begin
                        if (!found && sb[j].kind == k && sb[j].ch == c && sb[j].at == cyc) begin
                            sb.delete(j);
                            found = 1'b1;
                        end
                    end
                    if (!found) begin
                        n_fail++;
                        $display("FAIL %s_pulse ch%0d (cycle %0d): got 1, required 0 (no event expected)",
                                 kname(k), c, cyc);
                    end
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int e;
        rst_n  = 1'b0;
        raw_in = 4'hF;

        // Reset with raw high; all outputs stay 0.
        for (int k = 0; k < 3; k++) begin
            step(1);
            check_zero("reset_hold");
        end
        rst_n = 1'b1;
        e = cyc;
        for (int c = 0; c < 4; c++) expect_ev(0, c, e + 10);
        step(9);
        check_clean(4'h0, "release_edge8");
        step(1);
        check_clean(4'hF, "release_edge9");
        raw_in = 4'h0;
        e = cyc;
        for (int c = 0; c < 4; c++) expect_ev(1, c, e + 10);
        step(12);
        check_clean(4'h0, "release_fall");

        // Window boundary: 7-cycle excursion rejected, 8-cycle accepted.
        raw_in[1] = 1'b1;
        step(7);
        raw_in[1] = 1'b0;
        step(15);
        check_clean(4'h0, "window7_reject");
        raw_in[1] = 1'b1;
        e = cyc;
        expect_ev(0, 1, e + 10);
        step(8);
        raw_in[1] = 1'b0;
        expect_ev(1, 1, cyc + 10);
        step(9);
        check_clean(4'h2, "window8_accept");
        step(12);
        check_clean(4'h0, "window8_fall");

        // Bounce: 1 x5, 0 x2, then steady 1 -> single rise.
        raw_in[0] = 1'b1;
        step(5);
        raw_in[0] = 1'b0;
        step(2);
        raw_in[0] = 1'b1;
        e = cyc;
        expect_ev(0, 0, e + 10);
        step(9);
        check_clean(4'h0, "bounce_pending");
        step(3);
        check_clean(4'h1, "bounce_settled");
        raw_in[0] = 1'b0;
        expect_ev(1, 0, cyc + 10);
        step(12);
        check_clean(4'h0, "bounce_fall");

        // Hold: 40-cycle press fires one hold 20 cycles after rise.
        raw_in[2] = 1'b1;
        e = cyc;
        expect_ev(0, 2, e + 10);
        expect_ev(2, 2, e + 30);
        step(40);
        check_clean(4'h4, "hold_long_high");
        raw_in[2] = 1'b0;
        expect_ev(1, 2, cyc + 10);
        step(12);
        check_clean(4'h0, "hold_long_fall");

        // 19-cycle press: clean high one cycle short of a hold.
        raw_in[2] = 1'b1;
        e = cyc;
        expect_ev(0, 2, e + 10);
        step(19);
        raw_in[2] = 1'b0;
        expect_ev(1, 2, cyc + 10);
        step(12);
        check_clean(4'h0, "hold_short_fall");

        // Independence: ch0 steady, ch3 bounces 4 cycles; both fall together.
        raw_in = 4'b1001;
        e = cyc;
        expect_ev(0, 0, e + 10);
        expect_ev(0, 3, e + 14);
        step(1); raw_in[3] = 1'b0;
        step(1); raw_in[3] = 1'b1;
        step(1); raw_in[3] = 1'b0;
        step(1); raw_in[3] = 1'b1;
        step(8);
        check_clean(4'b0001, "indep_ch0_only");
        step(4);
        check_clean(4'b1001, "indep_both");
        raw_in = 4'h0;
        expect_ev(1, 0, cyc + 10);
        expect_ev(1, 3, cyc + 10);
        step(12);
        check_clean(4'h0, "indep_fall");

        // Reset mid-hold: no hold, no fall; re-debounced after release.
        raw_in[2] = 1'b1;
        e = cyc;
        expect_ev(0, 2, e + 10);
        step(25);
        rst_n = 1'b0;
        step(3);
        check_zero("midhold_reset");
        rst_n = 1'b1;
        e = cyc;
        expect_ev(0, 2, e + 10);
        expect_ev(2, 2, e + 30);
        step(10);
        check_clean(4'h4, "midhold_rerise");
        step(25);
        raw_in[2] = 1'b0;
        expect_ev(1, 2, cyc + 10);
        step(15);
        check_clean(4'h0, "midhold_fall");

        // Any event still pending never appeared.
        foreach (sb[j]) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_%s_pulse ch%0d: got none, required at cycle %0d",
                     kname(sb[j].kind), sb[j].ch, sb[j].at);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
